port_reset_sequencer: RTL and testbench
=======================================

Name: port_reset_sequencer

Overview:
- Generates the per-port reset bus `o_rst_bus[NUM_PORTS-1:0]` consumed by the port clock/reset fan-out stage.
- After global reset, holds all ports in reset, then releases enabled ports one at a time in index order, each gated on its own lock/ready input.
- In run mode, re-resets a single port on lock loss or on a software request, without disturbing the other ports.

Parameters:
- NUM_PORTS, 8, number of Ethernet ports / reset bus width.
- HOLD_CYCLES, 16, minimum reset assertion after global reset and for per-port recovery.
- STAGGER_CYCLES, 4, spacing between consecutive port releases during initial sequencing.
- TIMEOUT_CYCLES, 1024, maximum wait for a port's lock during initial sequencing.

Ports:
- i_clk  input  1  single clock for all logic.
- i_rst  input  1  global reset; asynchronous, active-high.
- i_lock  input  NUM_PORTS  per-port PLL lock / PHY ready; asynchronous, 2-flop synchronized internally.
- i_port_en  input  NUM_PORTS  static per-port enable; must not change outside i_rst.
- i_soft_rst_req  input  NUM_PORTS  synchronous single-cycle per-port reset request pulses.
- o_rst_bus  output  NUM_PORTS  per-port reset, active-high, registered.
- o_busy  output  1  high while initial sequencing is in progress.
- o_all_ready  output  1  high in RUN when every enabled port has o_rst_bus=0.
- o_timeout  output  NUM_PORTS  sticky flag; port never locked during initial sequencing.

Behaviour:
- Reset values while i_rst=1:
  - o_rst_bus = all 1s, o_busy = 1, o_all_ready = 0, o_timeout = 0.
  - Sync flops cleared; FSM in HOLD.
- Lock synchronization: 2-flop synchronizer, so i_lock changes are visible to the logic 2 cycles later ("slock").
- Edge numbering: edge 1 is the first rising i_clk edge after i_rst falls.
- HOLD:
  - Counts HOLD_CYCLES edges; enters RELEASE at edge HOLD_CYCLES with ptr = 0.
  - Soft requests are ignored.
- RELEASE, port `ptr`:
  - i_port_en[ptr]=0: port stays in reset; ptr advances after 1 cycle.
  - i_port_en[ptr]=1 with slock high: o_rst_bus[ptr] clears at the next edge. Release of port p+1 occurs exactly STAGGER_CYCLES edges after release of port p, provided its lock is already high.
  - Lock-high case, default parameters: port p releases at edge 17+4p.
  - No slock within TIMEOUT_CYCLES cycles of slot entry: set o_timeout[ptr], keep the port in reset, advance next cycle.
  - Soft requests are ignored.
  - After the last port's slot completes (including its stagger wait), enter RUN. On RUN entry, o_busy <= 0 and o_all_ready is evaluated from the same edge.
- RUN, per port independently (enabled ports only):
  - slock falling, or i_soft_rst_req pulse: o_rst_bus[p] <= 1 next edge; per-port counter loads HOLD_CYCLES.
  - Release (o_rst_bus[p] <= 0) when the counter has expired AND slock is high. Released exactly HOLD_CYCLES edges after assertion if lock is high.
  - Request during recovery: restarts the counter.
  - Lock loss during recovery: release waits for lock to return.
  - A soft request on a timed-out port clears o_timeout[p] and runs normal recovery.
  - Disabled ports: o_rst_bus stays 1 forever; requests ignored.
- o_all_ready: registered AND over enabled ports of ~o_rst_bus, qualified by RUN; drops the edge after any enabled port's reset reasserts.
- All ports disabled: RELEASE takes NUM_PORTS cycles; RUN is entered with o_all_ready=1.
- Simultaneous requests on multiple ports: each handled independently; no serialization in RUN.
- i_rst asserted mid-operation: all outputs immediately return to reset values (async); sequencing restarts from HOLD.
- Counter widths: $clog2 of the respective parameter + 1. No wrap: counters saturate at 0.

Test Plan:
- All i_lock=1, all enabled, defaults, release i_rst -> o_rst_bus[p] falls at edge 17+4p (17..45); o_busy=0 and o_all_ready=1 at edge 49.
- i_port_en=8'b1111_0101, locks high -> ports 1, 3 stay in reset permanently; enabled ports release in order with 4-cycle spacing after each 1-cycle skip; o_all_ready=1 in RUN.
- i_lock[2]=0 throughout -> o_timeout[2]=1 after 1024 cycles in slot 2; port 2 remains in reset; ports 3..7 continue; o_all_ready stays 0. Then raise lock[2] and pulse soft_rst_req[2] -> o_timeout[2] clears, port 2 releases 16 edges after its reset reasserts.
- In RUN, drop i_lock[5] for 3 cycles -> o_rst_bus[5] rises 3 edges later (2 sync + 1 reg); o_all_ready falls next edge; release after HOLD once lock is back; other ports untouched.
- Soft pulses on ports 0 and 7 in the same cycle, plus a second pulse on port 0 after 10 cycles -> port 7 releases after 16 edges; port 0 releases 16 edges after the second pulse.
- Assert i_rst during RELEASE at ptr=4 -> all o_rst_bus=1, o_busy=1, o_timeout=0 asynchronously; full sequence repeats after deassertion.

Source files
------------

// File: rtl/port_reset_sequencer.sv
// Per-port reset sequencer: holds all ports after global reset, releases enabled ports
// one at a time in index order gated on lock, then re-resets single ports on lock loss or request.
module port_reset_sequencer #(
    parameter int NUM_PORTS      = 8,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_PORTS-1:0] i_lock,
    input  logic [NUM_PORTS-1:0] i_port_en,
    input  logic [NUM_PORTS-1:0] i_soft_rst_req,
    output logic [NUM_PORTS-1:0] o_rst_bus,
    output logic                 o_busy,
    output logic                 o_all_ready,
    output logic [NUM_PORTS-1:0] o_timeout,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_STAGGER = 2'd2,
        S_RUN     = 2'd3
    } state_e;

    localparam int PTR_W  = $clog2(NUM_PORTS + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int STAG_W = $clog2(STAGGER_CYCLES) + 1;
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_CYCLES);
    localparam logic [STAG_W-1:0] STAG_LD = STAG_W'(STAGGER_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LD  = TMO_W'(TIMEOUT_CYCLES);

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [STAG_W-1:0]      stag_cnt_q, stag_cnt_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [NUM_PORTS-1:0]   sync1_q, slock_q, slock_prev_q;
    logic [NUM_PORTS-1:0]   rst_bus_q, rst_bus_d;
    logic                   busy_q, busy_d;
    logic                   all_ready_q, all_ready_d;
    logic [NUM_PORTS-1:0]   timeout_q, timeout_d;
    logic [NUM_PORTS-1:0]   rec_q, rec_d;
    logic [HOLD_W-1:0]      rec_cnt_q [NUM_PORTS];
    logic [HOLD_W-1:0]      rec_cnt_d [NUM_PORTS];
    logic [NUM_PORTS-1:0]   slot_oh;
    logic                   sel_en, sel_lock, advance;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        stag_cnt_d  = stag_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        rst_bus_d   = rst_bus_q;
        timeout_d   = timeout_q;
        rec_d       = rec_q;
        rec_cnt_d   = rec_cnt_q;
        advance     = 1'b0;
        slot_oh     = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (ptr_q == PTR_W'(p)) slot_oh[p] = 1'b1;
        end
        sel_en   = |(slot_oh & i_port_en);
        sel_lock = |(slot_oh & slock_q);

        case (state_q)
            S_HOLD: begin
                if (hold_cnt_q <= HOLD_W'(1)) begin
                    state_d   = S_RELEASE;
                    ptr_d     = '0;
                    tmo_cnt_d = TMO_LD;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            S_RELEASE: begin
                // ptr == NUM_PORTS is the one-cycle hand-off slot after the last port.
                if (ptr_q == PTR_W'(NUM_PORTS)) begin
                    state_d = S_RUN;
                end else if (!sel_en) begin
                    advance = 1'b1;
                end else if (sel_lock) begin
                    rst_bus_d  = rst_bus_q & ~slot_oh;
                    stag_cnt_d = STAG_LD;
                    state_d    = S_STAGGER;
                end else if (tmo_cnt_q <= TMO_W'(1)) begin
                    timeout_d = timeout_q | slot_oh;
                    advance   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
                end
            end
            S_STAGGER: begin
                if (stag_cnt_q <= STAG_W'(1)) advance = 1'b1;
                else stag_cnt_d = stag_cnt_q - STAG_W'(1);
            end
            default: begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (i_port_en[p]) begin
                        if ((slock_prev_q[p] && !slock_q[p]) || i_soft_rst_req[p]) begin
                            rst_bus_d[p] = 1'b1;
                            rec_d[p]     = 1'b1;
                            rec_cnt_d[p] = HOLD_LD;
                            if (i_soft_rst_req[p]) timeout_d[p] = 1'b0;
                        end else if (rec_q[p]) begin
                            if (rec_cnt_q[p] != '0) rec_cnt_d[p] = rec_cnt_q[p] - HOLD_W'(1);
                            // Only ports under recovery release, so a timed-out port stays down until requested.
                            if (rec_cnt_q[p] <= HOLD_W'(1) && slock_q[p]) begin
                                rst_bus_d[p] = 1'b0;
                                rec_d[p]     = 1'b0;
                            end
                        end
                    end
                end
            end
        endcase

        if (advance) begin
            ptr_d     = ptr_q + PTR_W'(1);
            tmo_cnt_d = TMO_LD;
            state_d   = S_RELEASE;
        end

        busy_d      = (state_d != S_RUN);
        all_ready_d = (state_d == S_RUN) && (&(~rst_bus_q | ~i_port_en));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_HOLD;
            ptr_q        <= '0;
            hold_cnt_q   <= HOLD_LD;
            stag_cnt_q   <= '0;
            tmo_cnt_q    <= TMO_LD;
            sync1_q      <= '0;
            slock_q      <= '0;
            slock_prev_q <= '0;
            rst_bus_q    <= '1;
            busy_q       <= 1'b1;
            all_ready_q  <= 1'b0;
            timeout_q    <= '0;
            rec_q        <= '0;
            for (int p = 0; p < NUM_PORTS; p++) rec_cnt_q[p] <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            stag_cnt_q   <= stag_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            sync1_q      <= i_lock;
            slock_q      <= sync1_q;
            slock_prev_q <= slock_q;
            rst_bus_q    <= rst_bus_d;
            busy_q       <= busy_d;
            all_ready_q  <= all_ready_d;
            timeout_q    <= timeout_d;
            rec_q        <= rec_d;
            rec_cnt_q    <= rec_cnt_d;
        end
    end

    assign o_rst_bus   = rst_bus_q;
    assign o_busy      = busy_q;
    assign o_all_ready = all_ready_q;
    assign o_timeout   = timeout_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_port_reset_sequencer.sv
// Bench for port_reset_sequencer: table of initial-sequencing scenarios plus
// hand-written recovery, simultaneous-request and mid-sequence reset cases.
module tb_port_reset_sequencer;

    localparam int N    = 8;
    localparam int HOLD = 16;
    localparam int STAG = 4;
    localparam int TMO  = 1024;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] lock = '1;
    logic [N-1:0] port_en = '1;
    logic [N-1:0] soft_req = '0;
    logic [N-1:0] rst_bus;
    logic         busy;
    logic         all_ready;
    logic [N-1:0] timeout;
    logic [1:0]   dbg_state;

    port_reset_sequencer #(
        .NUM_PORTS(N), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_lock(lock), .i_port_en(port_en),
        .i_soft_rst_req(soft_req), .o_rst_bus(rst_bus), .o_busy(busy),
        .o_all_ready(all_ready), .o_timeout(timeout), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int edge_n;
    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Expected port releases {port, edge}, in the order they must occur.
    logic [19:0]  exp_q[$];
    logic [19:0]  sb_e;
    logic [N-1:0] prev_bus = '1;

    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < N; p++) begin
                if (prev_bus[p] && !rst_bus[p]) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL release_unexpected: port %0d fell at edge %0d, none expected", p, edge_n);
                    end else begin
                        sb_e = exp_q.pop_front();
                        if (sb_e !== {4'(p), 16'(edge_n)}) begin
                            n_fail++;
                            $display("FAIL release_edge: got port %0d edge %0d, expected port %0d edge %0d",
                                     p, edge_n, sb_e[19:16], sb_e[15:0]);
                        end
                    end
                end
            end
        end
        prev_bus = rst_bus;
    end

    task automatic push_release(input int p, input int e);
        exp_q.push_back({4'(p), 16'(e)});
    endtask

    // Assert reset (checking async reset values), set inputs, push modelled release edges, release reset.
    task automatic start_seq(input logic [N-1:0] en, input logic [N-1:0] lk);
        int t;
        exp_q.delete();
        rst = 1'b1;
        #1;
        check("rst_bus_reset", 32'(rst_bus), 32'hFF);
        check("busy_reset", 32'(busy), 32'd1);
        check("all_ready_reset", 32'(all_ready), 32'd0);
        check("timeout_reset", 32'(timeout), 32'd0);
        port_en  = en;
        lock     = lk;
        soft_req = '0;
        @(negedge clk);
        @(negedge clk);
        t = HOLD;
        for (int p = 0; p < N; p++) begin
            if (!en[p]) t = t + 1;
            else if (lk[p]) begin
                push_release(p, t + 1);
                t = t + STAG;
            end else t = t + TMO;
        end
        rst = 1'b0;
    endtask

    task automatic wait_run(input int exp_edge);
        int k;
        for (k = 0; k < 3000 && busy; k++) @(negedge clk);
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_entry_timeout: busy still 1 at edge %0d, expected 0 at edge %0d", edge_n, exp_edge);
        end else begin
            check("run_entry_edge", 32'(edge_n), 32'(exp_edge));
        end
    endtask

    typedef struct {
        logic [N-1:0] en;
        logic [N-1:0] lk;
        int           run_edge;
        logic [N-1:0] bus;
        logic         ready;
        logic [N-1:0] tmo;
    } vec_t;

    vec_t vecs[5];
    int   x;

    initial begin
        vecs[0] = '{8'hFF, 8'hFF,   49, 8'h00, 1'b1, 8'h00};
        vecs[1] = '{8'hF5, 8'hFF,   43, 8'h0A, 1'b1, 8'h00};
        vecs[2] = '{8'h00, 8'hFF,   25, 8'hFF, 1'b1, 8'h00};
        vecs[3] = '{8'h80, 8'hFF,   28, 8'h7F, 1'b1, 8'h00};
        vecs[4] = '{8'hFF, 8'hFB, 1069, 8'h04, 1'b0, 8'h04};

        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            start_seq(vecs[i].en, vecs[i].lk);
            wait_run(vecs[i].run_edge);
            check("run_all_ready", 32'(all_ready), 32'(vecs[i].ready));
            check("run_rst_bus", 32'(rst_bus), 32'(vecs[i].bus));
            check("run_timeout", 32'(timeout), 32'(vecs[i].tmo));
            repeat (3) @(negedge clk);
            check("sb_drain", 32'(exp_q.size()), 32'd0);
        end

        // Timed-out port 2: lock returns, software request recovers it.
        lock = 8'hFF;
        repeat (4) @(negedge clk);
        x = edge_n;
        soft_req = 8'h04;
        push_release(2, x + 1 + HOLD);
        @(negedge clk);
        soft_req = '0;
        check("tmo_cleared", 32'(timeout), 32'h00);
        check("tmo_port_in_rst", 32'(rst_bus), 32'h04);
        repeat (15) @(negedge clk);
        check("tmo_port_held", 32'(rst_bus), 32'h04);
        check("tmo_not_ready", 32'(all_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("tmo_ready", 32'(all_ready), 32'd1);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        // Lock loss on port 5 for three cycles.
        start_seq(8'hFF, 8'hFF);
        wait_run(49);
        repeat (2) @(negedge clk);
        x = edge_n;
        lock = 8'hDF;
        push_release(5, x + 3 + HOLD);
        repeat (2) @(negedge clk);
        check("lockloss_sync_delay", 32'(rst_bus), 32'h00);
        @(negedge clk);
        lock = 8'hFF;
        check("lockloss_rst", 32'(rst_bus), 32'h20);
        check("lockloss_ready_lag", 32'(all_ready), 32'd1);
        @(negedge clk);
        check("lockloss_ready_drop", 32'(all_ready), 32'd0);
        repeat (14) @(negedge clk);
        check("lockloss_held", 32'(rst_bus), 32'h20);
        repeat (2) @(negedge clk);
        check("lockloss_ready_back", 32'(all_ready), 32'd1);
        check("lockloss_released", 32'(rst_bus), 32'h00);

        // Simultaneous requests on ports 0 and 7, second request on port 0 ten cycles later.
        x = edge_n;
        soft_req = 8'h81;
        push_release(7, x + 1 + HOLD);
        @(negedge clk);
        soft_req = '0;
        check("dual_req_rst", 32'(rst_bus), 32'h81);
        repeat (9) @(negedge clk);
        soft_req = 8'h01;
        push_release(0, x + 11 + HOLD);
        @(negedge clk);
        soft_req = '0;
        check("restart_rst", 32'(rst_bus), 32'h81);
        repeat (5) @(negedge clk);
        check("dual_held", 32'(rst_bus), 32'h81);
        @(negedge clk);
        check("port7_released", 32'(rst_bus), 32'h01);
        repeat (12) @(negedge clk);
        check("dual_all_released", 32'(rst_bus), 32'h00);
        check("dual_ready", 32'(all_ready), 32'd1);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        // Global reset while port 4's slot is active, then a full re-sequence.
        start_seq(8'hFF, 8'hFF);
        repeat (32) @(negedge clk);
        check("midrel_busy", 32'(busy), 32'd1);
        check("midrel_partial", 32'(rst_bus), 32'hF0);
        start_seq(8'hFF, 8'hFF);
        wait_run(49);
        check("rerun_ready", 32'(all_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
